// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Optional checksum trailer is enabled by IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes big-endian into 32-bit words; emits a 1-cycle registered word pulse
// the cycle after the 4th byte, holding a partial word indefinitely while no bytes arrive.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        Reset,
  input  logic        i_byte_vld,
  input  logic [7:0]  i_byte_dat,
  output logic        o_last_byte,
  output logic        o_word_vld,
  output logic [31:0] o_word_dat
);

  logic [1:0]  r_idx;
  logic [23:0] r_shift;
  logic        r_word_vld;
  logic [31:0] r_word;

  assign o_last_byte = (r_idx == 2'(BYTES_PER_WORD - 1));
  assign o_word_vld  = r_word_vld;
  assign o_word_dat  = r_word;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_idx      <= 2'd0;
      r_shift    <= 24'd0;
      r_word_vld <= 1'b0;
      r_word     <= 32'd0;
    end else begin
      r_word_vld <= 1'b0;
      if (i_byte_vld) begin
        r_idx <= r_idx + 2'd1;
        // Earlier bytes have shifted up, so the first byte ends up in the MSB.
        if (o_last_byte) begin
          r_word_vld <= 1'b1;
          r_word     <= {r_shift, i_byte_dat};
        end else begin
          r_shift <= {r_shift[15:0], i_byte_dat};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a 16-bit word-count header, writes packed words to imem from address 0,
// holds the core in reset until done. Optional checksum trailer via IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = 1;

  state_t                   r_state;
  logic [7:0]               r_nhi;
  logic [8*HDR_BYTES-1:0]   r_n;
  logic [ADDR_W:0]          r_cnt;
  logic [ADDR_W-1:0]        r_addr;
  logic                     r_full;
  logic                     r_hold;
  logic                     r_done;
  logic                     r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]               r_csum;
`endif

  logic                     w_rx;
  logic                     w_acc;
  logic                     w_data_acc;
  logic                     w_last_byte;
  logic [8*HDR_BYTES-1:0]   w_n;

  // Once the final data byte is in, stop taking bytes until the state moves on.
  assign w_rx = (r_state == S_HDR0) || (r_state == S_HDR1) || (r_state == S_CSUM) ||
                ((r_state == S_DATA) && !r_full);
  assign in_ready   = w_rx & ~Reset;
  assign w_acc      = in_valid & in_ready;
  assign w_data_acc = w_acc & (r_state == S_DATA);
  assign w_n        = {r_nhi, in_data};

  imem_loader_byte_packer u_packer (
    .clk         (clk),
    .Reset       (Reset),
    .i_byte_vld  (w_data_acc),
    .i_byte_dat  (in_data),
    .o_last_byte (w_last_byte),
    .o_word_vld  (imem_we),
    .o_word_dat  (imem_wdata)
  );

  assign imem_addr = r_addr;
  assign cpu_hold  = r_hold;
  assign load_done = r_done;
  assign load_err  = r_err;
  assign word_cnt  = r_cnt;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_HDR0;
      r_nhi   <= 8'd0;
      r_n     <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_full  <= 1'b0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum  <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_HDR0: begin
          if (w_acc) begin
            r_nhi   <= in_data;
            r_state <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (w_acc) begin
            r_n <= w_n;
            if (w_n == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_state <= S_CSUM;
`else
              r_state <= S_DONE;
              r_hold  <= 1'b0;
              r_done  <= 1'b1;
`endif
            end else if (32'(w_n) > 32'(DEPTH)) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_data_acc) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ in_data;
`endif
            if (w_last_byte) begin
              r_addr <= r_cnt[ADDR_W-1:0];
              r_cnt  <= r_cnt + CNT_ONE;
              if (32'(r_cnt) + 32'd1 == 32'(r_n)) r_full <= 1'b1;
            end
          end
          // r_full is high exactly during the final word's write pulse.
          if (r_full) begin
            r_full <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state <= S_CSUM;
`else
            r_state <= S_DONE;
            r_hold  <= 1'b0;
            r_done  <= 1'b1;
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (w_acc) begin
            if (in_data == r_csum) begin
              r_state <= S_DONE;
              r_hold  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        S_DONE, S_ERR: begin
          if (start) begin
            r_state <= S_HDR0;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum  <= 8'd0;
`endif
          end
        end
        default: r_state <= S_HDR0;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header parsing, big-endian packing, bounds, reset and restart.
module tb_imem_loader;

  localparam int ADDR_W = 10;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              Reset;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   word_cnt;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Write monitor: imem_we is a full-cycle pulse, so each negedge sample sees it once.
  int                we_tot = 0;
  logic [31:0]       mem [4];
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W:0]   cnt_at_we;
  always @(negedge clk) begin
    if (imem_we) begin
      we_tot++;
      last_addr = imem_addr;
      cnt_at_we = word_cnt;
      if (imem_addr < 4) mem[imem_addr[1:0]] = imem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("rdy_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] q[$], input int gap, input bit csum);
    logic [7:0] x;
    x = 8'h00;
    foreach (q[i]) begin
      send_byte(q[i], gap);
      if (i >= 2) x = x ^ q[i];
    end
    if (csum && CSUM_ON) send_byte(x, gap);
  endtask

  task automatic wait_end(input string tag);
    int t;
    t = 0;
    while (!(load_done || load_err) && t < 40) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_finished"}, {31'd0, load_done | load_err}, 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    int base;

    Reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_imem_we",   {31'd0, imem_we},   32'd0);
    check("rst_imem_addr", 32'(imem_addr),     32'd0);
    check("rst_wdata",     imem_wdata,         32'd0);
    check("rst_cpu_hold",  {31'd0, cpu_hold},  32'd1);
    check("rst_done",      {31'd0, load_done}, 32'd0);
    check("rst_err",       {31'd0, load_err},  32'd0);
    check("rst_word_cnt",  32'(word_cnt),      32'd0);
    @(negedge clk);
    Reset = 1'b0;

    // Basic two-word load, back-to-back bytes
    base = we_tot;
    q = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h10, 8'h00, 8'hFF, 8'hFF};
    load(q, 0, 1'b1);
    wait_end("basic");
    check("basic_we_cnt",   32'(we_tot - base),  32'd2);
    check("basic_mem0",     mem[0],              32'h20080005);
    check("basic_mem1",     mem[1],              32'h1000FFFF);
    check("basic_last_adr", 32'(last_addr),      32'd1);
    check("basic_cnt_at_we", 32'(cnt_at_we),     32'd2);
    check("basic_hold",     {31'd0, cpu_hold},   32'd0);
    check("basic_done",     {31'd0, load_done},  32'd1);
    check("basic_err",      {31'd0, load_err},   32'd0);
    check("basic_word_cnt", 32'(word_cnt),       32'd2);
    check("done_in_ready",  {31'd0, in_ready},   32'd0);

    // Same stream with 3-cycle gaps between bytes
    pulse_start();
    check("restart_hold", {31'd0, cpu_hold},  32'd1);
    check("restart_done", {31'd0, load_done}, 32'd0);
    check("restart_cnt",  32'(word_cnt),      32'd0);
    check("restart_addr", 32'(imem_addr),     32'd0);
    mem[0] = 32'd0; mem[1] = 32'd0;
    base = we_tot;
    load(q, 3, 1'b1);
    wait_end("gaps");
    check("gaps_we_cnt", 32'(we_tot - base),  32'd2);
    check("gaps_mem0",   mem[0],              32'h20080005);
    check("gaps_mem1",   mem[1],              32'h1000FFFF);
    check("gaps_done",   {31'd0, load_done},  32'd1);

    // N == 0
    pulse_start();
    base = we_tot;
    q = {8'h00, 8'h00};
    load(q, 0, 1'b1);
    wait_end("n0");
    check("n0_done",   {31'd0, load_done}, 32'd1);
    check("n0_err",    {31'd0, load_err},  32'd0);
    check("n0_hold",   {31'd0, cpu_hold},  32'd0);
    check("n0_we_cnt", 32'(we_tot - base), 32'd0);

    // N > DEPTH
    pulse_start();
    base = we_tot;
    q = {8'h04, 8'h01};
    load(q, 0, 1'b0);
    wait_end("big");
    check("big_err",    {31'd0, load_err},  32'd1);
    check("big_hold",   {31'd0, cpu_hold},  32'd1);
    check("big_done",   {31'd0, load_done}, 32'd0);
    repeat (3) @(negedge clk);
    check("big_we_cnt", 32'(we_tot - base), 32'd0);

    // N == DEPTH fills the whole memory
    pulse_start();
    check("err_cleared", {31'd0, load_err}, 32'd0);
    base = we_tot;
    q.delete();
    q.push_back(8'h04);
    q.push_back(8'h00);
    for (int i = 0; i < 4096; i++) q.push_back(8'(i * 7 + 1));
    load(q, 0, 1'b1);
    wait_end("full");
    check("full_we_cnt",   32'(we_tot - base), 32'd1024);
    check("full_last_adr", 32'(last_addr),     32'd1023);
    check("full_word_cnt", 32'(word_cnt),      32'd1024);
    check("full_mem0",     mem[0],             32'h01080F16);
    check("full_done",     {31'd0, load_done}, 32'd1);

    // Reset after 5 data bytes
    pulse_start();
    q = {8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    load(q, 0, 1'b0);
    @(negedge clk);
    Reset = 1'b1;
    #1;
    check("mrst_hold",     {31'd0, cpu_hold},  32'd1);
    check("mrst_cnt",      32'(word_cnt),      32'd0);
    check("mrst_addr",     32'(imem_addr),     32'd0);
    check("mrst_wdata",    imem_wdata,         32'd0);
    check("mrst_in_ready", {31'd0, in_ready},  32'd0);
    @(negedge clk);
    Reset = 1'b0;
    base = we_tot;
    q = {8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    load(q, 0, 1'b1);
    wait_end("mrst");
    check("mrst_mem0",   mem[0],             32'hCAFEBABE);
    check("mrst_we_cnt", 32'(we_tot - base), 32'd1);
    check("mrst_done",   {31'd0, load_done}, 32'd1);

    // Restart from DONE; start mid-DATA must be ignored
    pulse_start();
    check("rs_hold", {31'd0, cpu_hold}, 32'd1);
    base = we_tot;
    q = {8'h00, 8'h01, 8'hDE, 8'hAD};
    load(q, 0, 1'b0);
    pulse_start();
    check("ign_hold", {31'd0, cpu_hold}, 32'd1);
    check("ign_done", {31'd0, load_done}, 32'd0);
    q = {8'hBE, 8'hEF};
    load(q, 0, 1'b0);
    if (CSUM_ON) send_byte(8'h22, 0);
    wait_end("rs");
    check("rs_mem0",   mem[0],             32'hDEADBEEF);
    check("rs_we_cnt", 32'(we_tot - base), 32'd1);
    check("rs_done",   {31'd0, load_done}, 32'd1);
    check("rs_cnt",    32'(word_cnt),      32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    q = {8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    load(q, 0, 1'b0);
    send_byte(8'h44, 0);
    wait_end("cs_ok");
    check("cs_ok_done", {31'd0, load_done}, 32'd1);
    pulse_start();
    mem[0] = 32'd0;
    load(q, 0, 1'b0);
    send_byte(8'h45, 0);
    wait_end("cs_bad");
    check("cs_bad_err",  {31'd0, load_err}, 32'd1);
    check("cs_bad_hold", {31'd0, cpu_hold}, 32'd1);
    check("cs_bad_mem0", mem[0],            32'h11223344);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
